guess_entry: RTL
================

Name: guess_entry

Overview:
- Player-side front end of the code-breaking game; the initiator whose guesses the feedback scorer grades.
- Builds a 4-slot guess (3-bit colour per slot) from debounced button pulses, then commits it to the history bus consumed by the scorer.
- Counts turns, drives last_turn toward the scorer, and locks all entry once game_over returns.

Parameters:
- MAX_TURNS, 10, guesses allowed per game; legal range 2..15.
- NUM_COLORS, 8, colours per slot; legal range 2..8; values 0..NUM_COLORS-1.
- SETTLE, 4, cycles spent in WAIT after a commit so the scorer can settle; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_next  in  1  one-cycle pulse; advance colour in the slot under the cursor
- btn_move  in  1  one-cycle pulse; advance cursor
- btn_submit  in  1  one-cycle pulse; commit the current guess
- game_over  in  1  from scorer; level
- cursor  out  2  slot being edited
- guess0..guess3  out  3 each  live editable guess, for display
- history0..history3  out  3 each  committed guess, to scorer
- guess_valid  out  1  one-cycle strobe, high in the cycle history changes
- turn  out  4  guesses committed so far
- last_turn  out  1  to scorer
- locked  out  1  high in DONE

Behaviour:
- Reset values: all guess*, history*, cursor, turn = 0; guess_valid, last_turn, locked = 0; state = EDIT.
- rst wins over everything, including mid-WAIT and DONE.
- All outputs are registered.
- States:
  - EDIT: accepts buttons.
  - WAIT: counts SETTLE cycles; all buttons ignored.
  - DONE: everything ignored until rst.
- EDIT, btn_next: slot[cursor] <= slot+1, wrapping NUM_COLORS-1 -> 0.
- EDIT, btn_move: cursor <= cursor+1, wrapping 3 -> 0.
- btn_next and btn_move in the same cycle: the colour change applies to the old cursor slot, and the cursor advances in the same edge.
- btn_submit in EDIT:
  - It has priority; next/move in that cycle are dropped.
  - On that edge: history* <= guess*; guess_valid <= 1 for exactly one cycle; turn <= turn+1; cursor <= 0; guess* retained; state -> WAIT with wait count 0.
- last_turn:
  - Set on the edge where turn becomes MAX_TURNS-1. It is therefore already high when the final guess's history is presented.
  - Sticky until rst.
- WAIT:
  - Stays for exactly SETTLE cycles after the commit edge.
  - Then -> DONE if turn == MAX_TURNS, else -> EDIT.
- game_over high in any state -> DONE on the next edge; locked <= 1.
- A resubmitted identical guess still pulses guess_valid and increments turn; history values are unchanged.
- turn saturates at MAX_TURNS. No submit is possible beyond it, because DONE is entered.

Decomposition:
- Shared game package holds:
  - COLOR_W = 3
  - NUM_SLOTS = 4
  - TURN_W = 4
  - the state encoding (EDIT, WAIT, DONE)
- The scorer reuses COLOR_W and NUM_SLOTS from the same package.
- One natural sub-module: color_slot. It is a per-slot 3-bit wrapping counter with enable and synchronous clear, instantiated 4×.

Test Plan:
- Reset, then btn_next ×3 and btn_move, then btn_next ×1 → guess0=3, guess1=1, cursor=1.
- btn_next ×9 on slot 0 with NUM_COLORS=8 → guess0=1 (wrap). btn_move ×5 → cursor=1.
- Set guess 1,2,3,4 then btn_submit → next edge: history=1,2,3,4, guess_valid high 1 cycle, turn=1, cursor=0. Buttons pressed during the next 4 cycles have no effect.
- MAX_TURNS=3, commit 3 guesses → last_turn rises with turn=2. The 3rd commit presents history with last_turn=1, turn=3, then DONE, locked=1.
- game_over asserted during WAIT → DONE next edge; later btn_submit leaves turn and history unchanged.
- Same-cycle btn_submit+btn_next+btn_move → only the commit occurs; guess* unchanged and cursor=0.

Source files
------------

// File: rtl/guess_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : guess_entry_pkg
//  Purpose  : Shared game constants, state encoding and colour helper.
//  Revision : 1.0 - initial release
// ============================================================================
package guess_entry_pkg;

  localparam int COLOR_W   = 3;
  localparam int NUM_SLOTS = 4;
  localparam int TURN_W    = 4;
  localparam int CURSOR_W  = 2;
  localparam int WAIT_W    = 4;

  localparam logic [1:0] EDIT = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef logic [COLOR_W-1:0] color_t;

  // Next colour in a ring of num_colors entries (num_colors-1 wraps to 0).
  function automatic color_t next_color(input color_t c, input int unsigned num_colors);
    return (c == color_t'(num_colors - 1)) ? '0 : c + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/guess_entry_color_slot.sv
`default_nettype none
// ============================================================================
//  Module   : color_slot
//  Purpose  : One guess slot; wrapping colour counter with enable and clear.
//  Revision : 1.0 - initial release
// ============================================================================
module color_slot
  import guess_entry_pkg::*;
#(
  parameter int NUM_COLORS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COLOR_W-1:0] value
);

  color_t r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (en) begin
      r_value <= next_color(r_value, NUM_COLORS);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
//  Module   : guess_entry
//  Purpose  : Player guess builder; edits slots, commits guesses, counts turns.
//  Revision : 1.0 - initial release
// ============================================================================
module guess_entry
  import guess_entry_pkg::*;
#(
  parameter int MAX_TURNS  = 10,
  parameter int NUM_COLORS = 8,
  parameter int SETTLE     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_next,
  input  logic               btn_move,
  input  logic               btn_submit,
  input  logic               game_over,
  output logic [1:0]         cursor,
  output logic [COLOR_W-1:0] guess0,
  output logic [COLOR_W-1:0] guess1,
  output logic [COLOR_W-1:0] guess2,
  output logic [COLOR_W-1:0] guess3,
  output logic [COLOR_W-1:0] history0,
  output logic [COLOR_W-1:0] history1,
  output logic [COLOR_W-1:0] history2,
  output logic [COLOR_W-1:0] history3,
  output logic               guess_valid,
  output logic [TURN_W-1:0]  turn,
  output logic               last_turn,
  output logic               locked
);

  logic [1:0]          r_state;
  logic [WAIT_W-1:0]   r_wait;
  logic [CURSOR_W-1:0] r_cursor;
  logic [TURN_W-1:0]   r_turn;
  color_t              r_hist [NUM_SLOTS];
  logic                r_gv;
  logic                r_last;
  logic                r_locked;

  color_t              w_guess [NUM_SLOTS];
  logic                w_slot_inc;
  logic [TURN_W-1:0]   w_turn_next;

  // Submit and game_over both pre-empt slot editing in the same cycle.
  assign w_slot_inc  = (r_state == EDIT) && !game_over && !btn_submit && btn_next;
  assign w_turn_next = (r_turn < TURN_W'(MAX_TURNS)) ? r_turn + 1'b1 : r_turn;

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      color_slot #(
        .NUM_COLORS(NUM_COLORS)
      ) u_slot (
        .clk  (clk),
        .rst  (rst),
        .en   (w_slot_inc && (r_cursor == CURSOR_W'(i))),
        .value(w_guess[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EDIT;
      r_wait   <= '0;
      r_cursor <= '0;
      r_turn   <= '0;
      r_gv     <= 1'b0;
      r_last   <= 1'b0;
      r_locked <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_hist[i] <= '0;
    end else begin
      r_gv <= 1'b0;
      if ((r_state != DONE) && game_over) begin
        r_state  <= DONE;
        r_locked <= 1'b1;
      end else begin
        case (r_state)
          EDIT: begin
            if (btn_submit) begin
              for (int i = 0; i < NUM_SLOTS; i++) r_hist[i] <= w_guess[i];
              r_gv     <= 1'b1;
              r_turn   <= w_turn_next;
              r_cursor <= '0;
              r_wait   <= '0;
              r_state  <= WAIT;
              // Raised with the next-to-last commit so it leads the final guess.
              if (w_turn_next == TURN_W'(MAX_TURNS - 1)) r_last <= 1'b1;
            end else if (btn_move) begin
              r_cursor <= r_cursor + 1'b1;
            end
          end
          WAIT: begin
            if (r_wait == WAIT_W'(SETTLE - 1)) begin
              if (r_turn == TURN_W'(MAX_TURNS)) begin
                r_state  <= DONE;
                r_locked <= 1'b1;
              end else begin
                r_state <= EDIT;
              end
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cursor      = r_cursor;
  assign guess0      = w_guess[0];
  assign guess1      = w_guess[1];
  assign guess2      = w_guess[2];
  assign guess3      = w_guess[3];
  assign history0    = r_hist[0];
  assign history1    = r_hist[1];
  assign history2    = r_hist[2];
  assign history3    = r_hist[3];
  assign guess_valid = r_gv;
  assign turn        = r_turn;
  assign last_turn   = r_last;
  assign locked      = r_locked;

endmodule
`default_nettype wire
